// File: rtl/bmlp_layer_sequencer_if.sv
// Handshake/control bundle between the binary-MLP layer sequencer and its datapath/host.
// The slave modport is the sequencer; the master modport is the host/datapath side.
interface bmlp_layer_sequencer_if #(
  parameter int CNT_W      = 7,
  parameter int NUM_LAYERS = 3,
  parameter int LAY_W      = 2
);
  logic                        start;
  logic [CNT_W-1:0]            in_end;
  logic [NUM_LAYERS*CNT_W-1:0] neur_end;
  logic                        in_valid;
  logic                        in_ready;
  logic                        rf_we;
  logic                        rf_wbank;
  logic [CNT_W-1:0]            rf_waddr;
  logic                        rf_rbank;
  logic [CNT_W-1:0]            rf_raddr;
  logic                        mac_en;
  logic                        mac_clr;
  logic                        wb_sel;
  logic [LAY_W-1:0]            layer;
  logic                        busy;
  logic                        done;

  modport slave (
    input  start, in_end, neur_end, in_valid,
    output in_ready, rf_we, rf_wbank, rf_waddr, rf_rbank, rf_raddr,
           mac_en, mac_clr, wb_sel, layer, busy, done
  );

  modport master (
    output start, in_end, neur_end, in_valid,
    input  in_ready, rf_we, rf_wbank, rf_waddr, rf_rbank, rf_raddr,
           mac_en, mac_clr, wb_sel, layer, busy, done
  );
endinterface

// File: rtl/bmlp_layer_sequencer.sv
// Control FSM for the binary MLP: loads the input vector into bank 0, then sweeps each
// neuron of each layer through the XNOR-popcount MAC and writes it to the opposite bank.
module bmlp_layer_sequencer #(
  parameter int CNT_W      = 7,
  parameter int NUM_LAYERS = 3,
  parameter int LAY_W      = 2
) (
  input logic                   clk,
  input logic                   rst,
  bmlp_layer_sequencer_if.slave bus
);

  localparam int NE_N = 1 << LAY_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWEEP, S_WB, S_DONE} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             ld_cnt, rd_cnt, neuron, in_end_q, src_end;
  logic [LAY_W-1:0]             layer;
  // Padded to a power of two so any layer index selects a defined entry.
  logic [NE_N-1:0][CNT_W-1:0]   ne_q;

  // Layer 0 reads the input vector; later layers read the previous layer's neurons.
  always_comb begin
    src_end = in_end_q;
    if (layer != '0) src_end = ne_q[layer - LAY_W'(1)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ld_cnt   <= '0;
      rd_cnt   <= '0;
      neuron   <= '0;
      layer    <= '0;
      in_end_q <= '0;
      ne_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          in_end_q <= bus.in_end;
          ne_q     <= '0;
          for (int l = 0; l < NUM_LAYERS; l++) ne_q[l] <= bus.neur_end[l*CNT_W +: CNT_W];
          ld_cnt   <= '0;
          rd_cnt   <= '0;
          neuron   <= '0;
          layer    <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: if (bus.in_valid) begin
          if (ld_cnt == in_end_q) begin
            ld_cnt <= '0;
            rd_cnt <= '0;
            neuron <= '0;
            layer  <= '0;
            state  <= S_SWEEP;
          end else begin
            ld_cnt <= ld_cnt + CNT_W'(1);
          end
        end
        S_SWEEP: begin
          if (rd_cnt == src_end) begin
            rd_cnt <= '0;
            state  <= S_WB;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          if (neuron != ne_q[layer]) begin
            neuron <= neuron + CNT_W'(1);
            state  <= S_SWEEP;
          end else if (layer != LAY_W'(NUM_LAYERS - 1)) begin
            layer  <= layer + LAY_W'(1);
            neuron <= '0;
            state  <= S_SWEEP;
          end else begin
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          layer  <= '0;
          neuron <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; the only input feed-through is rf_we following in_valid during LOAD.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_wbank = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_rbank = 1'b0;
    bus.rf_raddr = rd_cnt;
    bus.mac_en   = 1'b0;
    bus.mac_clr  = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.layer    = layer;
    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);
    case (state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.rf_we    = bus.in_valid;
        bus.rf_waddr = ld_cnt;
      end
      S_SWEEP: begin
        bus.mac_en   = 1'b1;
        bus.mac_clr  = (rd_cnt == '0);
        bus.rf_rbank = layer[0];
      end
      S_WB: begin
        bus.rf_we    = 1'b1;
        bus.wb_sel   = 1'b1;
        bus.rf_wbank = ~layer[0];
        bus.rf_waddr = neuron;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bmlp_layer_sequencer.sv
// Randomized bench: a loop-level schedule model (load words, then layers/neurons/words)
// predicts every output each cycle for several configurations, reset and stray inputs.
module tb_bmlp_layer_sequencer;
  localparam int CNT_W = 7, NUM_LAYERS = 3, LAY_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bmlp_layer_sequencer_if #(.CNT_W(CNT_W), .NUM_LAYERS(NUM_LAYERS), .LAY_W(LAY_W)) bus ();

  bmlp_layer_sequencer #(.CNT_W(CNT_W), .NUM_LAYERS(NUM_LAYERS), .LAY_W(LAY_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_chk = 0, n_fail = 0, busy_obs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {7'b0, bus.in_ready, bus.rf_we, bus.rf_wbank, bus.rf_waddr, bus.rf_rbank,
            bus.rf_raddr, bus.mac_en, bus.mac_clr, bus.wb_sel, bus.layer, bus.busy, bus.done};
  endfunction

  function automatic logic [31:0] mk(int ir, int we, int wb, int wa, int rb, int ra,
                                     int men, int mclr, int wsel, int lay, int bsy, int dn);
    return {7'b0, 1'(ir), 1'(we), 1'(wb), 7'(wa), 1'(rb), 7'(ra), 1'(men), 1'(mclr),
            1'(wsel), 2'(lay), 1'(bsy), 1'(dn)};
  endfunction

  // One cycle: drive inputs on the falling edge, then compare against the prediction.
  task automatic cyc(input string tag, input logic [31:0] exp, input bit vin, input bit noise);
    @(negedge clk);
    bus.in_valid = vin;
    bus.start    = 1'b0;
    if (noise) begin
      bus.start    = 1'($urandom);
      bus.in_end   = 7'($urandom);
      bus.neur_end = 21'($urandom);
    end
    #1;
    if (bus.busy) busy_obs++;
    chk(tag, obs(), exp);
  endtask

  // vmode: 0 = in_valid held high, 1 = toggling 1,0,1,..., 2 = random
  // abort: assert reset asynchronously in the second word of layer 1's first sweep
  task automatic run(input int ie, input int ne0, input int ne1, input int ne2,
                     input int vmode, input bit noise, input bit abort);
    int ne[3];
    int cnt, c, src;
    bit v;
    ne[0] = ne0; ne[1] = ne1; ne[2] = ne2;
    busy_obs = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_end   = 7'(ie);
    bus.neur_end = {7'(ne2), 7'(ne1), 7'(ne0)};
    bus.in_valid = 1'($urandom);
    #1;
    chk("idle_pre", obs(), 32'h0);
    cnt = 0; c = 0;
    while (cnt <= ie) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(c % 2 == 0) : 1'($urandom);
      cyc($sformatf("load c%0d", c), mk(1, v, 0, cnt, 0, 0, 0, 0, 0, 0, 1, 0), v, noise);
      if (v) cnt++;
      c++;
    end
    for (int l = 0; l < NUM_LAYERS; l++) begin
      src = (l == 0) ? ie : ne[l-1];
      for (int n = 0; n <= ne[l]; n++) begin
        for (int r = 0; r <= src; r++) begin
          cyc($sformatf("sweep l%0d n%0d r%0d", l, n, r),
              mk(0, 0, 0, 0, l % 2, r, 1, r == 0, 0, l, 1, 0), 1'($urandom), noise);
          if (abort && l == 1 && r == 1) begin
            #2 rst = 1'b1;
            #1 chk("rst_async", obs(), 32'h0);
            bus.start = 1'b0;
            @(negedge clk);
            #1 chk("rst_hold", obs(), 32'h0);
            rst = 1'b0;
            return;
          end
        end
        cyc($sformatf("wb l%0d n%0d", l, n),
            mk(0, 1, (l + 1) % 2, n, 0, 0, 0, 0, 1, l, 1, 0), 1'($urandom), noise);
      end
    end
    cyc("done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NUM_LAYERS - 1, 1, 1), 1'($urandom), noise);
    cyc("idle_post", 32'h0, 1'($urandom), 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_end = '0; bus.neur_end = '0; bus.in_valid = 1'b1;
    #12;
    chk("reset", obs(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset", obs(), 32'h0);

    run(3, 2, 1, 0, 0, 1'b0, 1'b0);
    chk("busy_len_base", 32'(busy_obs), 32'd31);
    run(3, 2, 1, 0, 1, 1'b0, 1'b0);
    run(0, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("busy_len_min", 32'(busy_obs), 32'd8);
    run(127, 0, 0, 0, 0, 1'b0, 1'b0);
    run(3, 2, 1, 0, 0, 1'b0, 1'b1);
    run(3, 2, 1, 0, 0, 1'b0, 1'b0);
    chk("busy_len_after_rst", 32'(busy_obs), 32'd31);
    run(3, 2, 1, 0, 2, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), 2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bmlp_layer_sequencer.md
Name: bmlp_layer_sequencer

Overview:
- Top-level control FSM for the binary MLP datapath.
- Loads an input vector into the ping-pong register file, then runs every layer. For each neuron it sweeps the source bank through the XNOR-popcount MAC and writes the result back to the opposite bank.
- Owns the 7-bit write-address, read-address and neuron-index counters. Each counter uses terminal-count ("end_count") semantics.

Parameters:
- CNT_W, 7, width of all address/index counters and terminal counts.
- NUM_LAYERS, 3, number of layers executed per run (1..4).
- LAY_W, 2, width of the layer index output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- in_end  in  CNT_W  input words minus 1; latched on accepted start.
- neur_end  in  NUM_LAYERS*CNT_W  per-layer neuron count minus 1; slice l at bits [l*CNT_W +: CNT_W]; latched on accepted start.
- in_valid  in  1  input word present on the datapath.
- in_ready  out  1  sequencer accepts an input word this cycle.
- rf_we  out  1  register-file write enable.
- rf_wbank  out  1  bank written.
- rf_waddr  out  CNT_W  write address.
- rf_rbank  out  1  bank read.
- rf_raddr  out  CNT_W  read address.
- mac_en  out  1  MAC accumulates the word at rf_raddr.
- mac_clr  out  1  MAC clears before accumulating (first word of a sweep).
- wb_sel  out  1  write data comes from the MAC/sign result, not the input.
- layer  out  LAY_W  current layer index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- States: IDLE, LOAD, SWEEP, WB, DONE.
- Outputs are Moore, decoded from the state and counter registers.
- Reset (any time, including mid-run): state=IDLE; all counters, layer and latched ends = 0. Every output is 0 except rf_raddr=0, rf_waddr=0 and in_ready=0.
- IDLE: start=1 latches in_end and neur_end, clears the counters and goes to LOAD. start outside IDLE is ignored.
- LOAD:
  - in_ready=1, rf_wbank=0, wb_sel=0, rf_waddr=ld_cnt.
  - rf_we = in_valid. ld_cnt increments on each handshake.
  - The handshake with ld_cnt==in_end goes to SWEEP with layer=0, neuron=0, rd_cnt=0.
  - in_valid=0 stalls LOAD indefinitely.
- SWEEP:
  - mac_en=1 every cycle; mac_clr=1 only when rd_cnt==0.
  - rf_rbank=layer[0]; rf_raddr=rd_cnt.
  - Source end = in_end for layer 0, otherwise neur_end[layer-1].
  - rd_cnt increments each cycle. At rd_cnt==source end, go to WB; rd_cnt returns to 0.
- WB (exactly 1 cycle):
  - rf_we=1, wb_sel=1, rf_wbank=~layer[0], rf_waddr=neuron.
  - If neuron<neur_end[layer]: neuron++, back to SWEEP.
  - Otherwise, if layer<NUM_LAYERS-1: layer++, neuron=0, back to SWEEP.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. Final results sit in bank NUM_LAYERS%2.
- Cycle counts:
  - LOAD takes (in_end+1) cycles when in_valid is held high.
  - Each neuron takes (source end+1) SWEEP cycles plus 1 WB cycle.
  - No bubbles between states.
- Counters compare against the terminal value and never exceed it. A terminal of 127 gives a 128-cycle sweep with no overflow. A terminal of 0 gives a single-cycle sweep, with mac_clr and mac_en high together.
- in_valid is ignored outside LOAD. Latched ends stay stable for the whole run regardless of input changes.

Test Plan:
- in_end=3, neur_end={L2=0,L1=1,L0=2}, start, in_valid held 1 -> waddr 0..3 on bank 0 over 4 cycles. Then 15 (L0) + 8 (L1) + 3 (L2) = 26 compute cycles, WB addresses 0,1,2 / 0,1 / 0. done pulses exactly 31 cycles after the cycle start is sampled (4 LOAD + 26 compute + 1 DONE); busy low the cycle after done.
- Same config, in_valid toggled 1,0,1,0,... -> exactly 4 writes to addresses 0..3; no rf_we while in_valid=0; SWEEP entered after the 4th handshake.
- in_end=0, all neur_end=0 -> every SWEEP is 1 cycle with mac_clr=mac_en=1; the run completes in 1 + 3×2 + 1 = 8 cycles.
- in_end=127, neur_end L0=0 -> rf_raddr 0..127 in one sweep, no wrap; WB at address 0 on bank 1.
- Assert rst asynchronously mid-SWEEP of layer 1 -> all outputs 0 immediately; a following start runs the full 31-cycle sequence from the first scenario.
- start pulsed during LOAD and SWEEP, neur_end changed mid-run -> no restart; the schedule matches the first latched configuration.
